// File: rtl/alu_pkg.sv
// Shared encodings for the RV32IM R-type ALU: funct3 and funct7 field values.
package alu_pkg;

    // funct3 selects the operation within the base or M group
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // funct7 distinguishes base ops, their SUB/SRA alternates and the M extension
    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

endpackage

// File: rtl/alu_divider.sv
// Combinational signed/unsigned divider producing quotient and remainder,
// including the RISC-V divide-by-zero and signed-overflow results.
module alu_divider
    import alu_pkg::*;
(
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_signed,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_mag_q;
    logic [31:0] w_mag_r;

    // Divide magnitudes unsigned, then restore signs: the quotient is negative
    // when operand signs differ, the remainder follows the dividend.
    always_comb begin
        w_neg_a     = i_signed & i_dividend[31];
        w_neg_b     = i_signed & i_divisor[31];
        w_mag_a     = w_neg_a ? (~i_dividend + 32'd1) : i_dividend;
        w_mag_b     = w_neg_b ? (~i_divisor + 32'd1) : i_divisor;
        w_mag_q     = 32'd0;
        w_mag_r     = 32'd0;
        o_quotient  = 32'hFFFF_FFFF;
        o_remainder = i_dividend;
        if (i_divisor == 32'd0) begin
            // x/0 -> all ones, x%0 -> x (same for signed and unsigned)
            o_quotient  = 32'hFFFF_FFFF;
            o_remainder = i_dividend;
        end else if (i_signed && i_dividend == 32'h8000_0000 && i_divisor == 32'hFFFF_FFFF) begin
            // most-negative / -1 cannot be represented; wrap to the dividend
            o_quotient  = 32'h8000_0000;
            o_remainder = 32'd0;
        end else begin
            w_mag_q     = w_mag_a / w_mag_b;
            w_mag_r     = w_mag_a % w_mag_b;
            o_quotient  = (w_neg_a ^ w_neg_b) ? (~w_mag_q + 32'd1) : w_mag_q;
            o_remainder = w_neg_a ? (~w_mag_r + 32'd1) : w_mag_r;
        end
    end

endmodule

// File: rtl/riscv_alu.sv
// RV32IM R-type ALU: combinational result on rd plus a registered copy rd_q.
module riscv_alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd,
    output logic [31:0] rd_q
);

    logic        w_is_muldiv;
    logic        w_alt;
    logic [4:0]  w_shamt;
    logic [32:0] w_mul_a;
    logic [32:0] w_mul_b;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_base;
    logic [31:0] w_mdv;
    logic [31:0] r_rd_q;

    assign w_is_muldiv = (funct7 == F7_MULDIV);
    assign w_alt       = funct7[5];
    assign w_shamt     = rs2[4:0];

    // Operand extension: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    // The 33x33 signed product covers every signedness mix without overflow.
    assign w_mul_a = {((funct3 == 3'd1) || (funct3 == 3'd2)) & rs1[31], rs1};
    assign w_mul_b = {(funct3 == 3'd1) & rs2[31], rs2};
    assign w_prod  = $signed({{31{w_mul_a[32]}}, w_mul_a}) * $signed({{31{w_mul_b[32]}}, w_mul_b});

    // DIV/REM use funct3 values 4 and 6 (signed); 5 and 7 are unsigned.
    alu_divider u_div (
        .i_dividend  (rs1),
        .i_divisor   (rs2),
        .i_signed    (~funct3[0]),
        .o_quotient  (w_quot),
        .o_remainder (w_rem)
    );

    // Base integer operations selected by funct3, funct7[5] picks SUB/SRA
    always_comb begin
        w_base = 32'd0;
        case (funct3)
            F3_ADD:  w_base = w_alt ? (rs1 - rs2) : (rs1 + rs2);
            F3_SLL:  w_base = rs1 << w_shamt;
            F3_SLT:  w_base = {31'd0, $signed(rs1) < $signed(rs2)};
            F3_SLTU: w_base = {31'd0, rs1 < rs2};
            F3_XOR:  w_base = rs1 ^ rs2;
            F3_SR:   w_base = w_alt ? 32'($signed(rs1) >>> w_shamt) : (rs1 >> w_shamt);
            F3_OR:   w_base = rs1 | rs2;
            F3_AND:  w_base = rs1 & rs2;
            default: w_base = 32'd0;
        endcase
    end

    // M-extension result: multiply halves or divider outputs
    always_comb begin
        w_mdv = 32'd0;
        case (funct3)
            3'd0:    w_mdv = w_prod[31:0];
            3'd1,
            3'd2,
            3'd3:    w_mdv = w_prod[63:32];
            3'd4,
            3'd5:    w_mdv = w_quot;
            default: w_mdv = w_rem;
        endcase
    end

    assign rd = w_is_muldiv ? w_mdv : w_base;

    // Writeback copy of rd; reset clears it without waiting for a clock edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_q <= 32'd0;
        else     r_rd_q <= rd;
    end

    assign rd_q = r_rd_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Self-checking bench for riscv_alu: directed cases from the ALU's defined
// behaviour, then random operations against a 64-bit arithmetic reference.
module tb_riscv_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
    logic [31:0] rd_q;

    int n_checks = 0;
    int n_pass   = 0;

    riscv_alu dut (
        .clk    (clk),
        .rst    (rst),
        .funct7 (funct7),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .rd_q   (rd_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on 64-bit integer arithmetic
    function automatic logic [31:0] model(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          ua;
        longint          ub;
        longint          p;
        longint unsigned pu;
        int              ia;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = int'(a);
        r  = 32'd0;
        if (f7 == 7'h01) begin
            case (f3)
                3'd0: begin p = sa * sb; r = p[31:0]; end
                3'd1: begin p = sa * sb; r = p[63:32]; end
                3'd2: begin p = sa * ub; r = p[63:32]; end
                3'd3: begin pu = longint'(ua) * longint'(ub); r = pu[63:32]; end
                3'd4: begin if (b == 0) r = 32'hFFFFFFFF; else begin p = sa / sb; r = p[31:0]; end end
                3'd5: begin if (b == 0) r = 32'hFFFFFFFF; else begin p = ua / ub; r = p[31:0]; end end
                3'd6: begin if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end end
                default: begin if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end end
            endcase
        end else begin
            case (f3)
                3'd0: begin p = f7[5] ? (sa - sb) : (sa + sb); r = p[31:0]; end
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = f7[5] ? 32'(ia >>> b[4:0]) : (a >> b[4:0]);
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Apply an operation after a falling edge and check rd combinationally
    task automatic op(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        funct7 = f7;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        #1;
        check(tag, rd, exp);
        $display("op %-8s f7=%h f3=%0d rs1=%h rs2=%h rd=%h", tag, f7, f3, a, b, rd);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 7));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;

        rst = 1'b1; funct7 = F7_BASE; funct3 = F3_ADD; rs1 = 32'd0; rs2 = 32'd0;
        #2;
        check("reset_rd_q", rd_q, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        op("ADD",    F7_BASE,   F3_ADD,  4,  6, 10);
        op("ADDn",   F7_BASE,   F3_ADD, -2, -4, -6);
        op("SUB",    F7_ALT,    F3_ADD,  4,  6, -2);
        op("SUBn",   F7_ALT,    F3_ADD, -2, -4,  2);
        op("MUL",    F7_MULDIV, 3'd0,    4,  6, 24);
        op("MULn",   F7_MULDIV, 3'd0,   -2, -4,  8);
        op("SLL",    F7_BASE,   F3_SLL,  4,  2, 16);
        op("SLLn",   F7_BASE,   F3_SLL, -2,  3, -16);
        op("SLLbig", F7_BASE,   F3_SLL,  1, 32'hFFFF_FFE3, 8);
        op("SRL",    F7_BASE,   F3_SR, -16,  3, 32'h1FFF_FFFE);
        op("SRA",    F7_ALT,    F3_SR, -16,  3, -2);
        op("SLT",    F7_BASE,   F3_SLT,  4,  6, 1);
        op("SLTn",   F7_BASE,   F3_SLT, -2, -4, 0);
        op("SLTU",   F7_BASE,   F3_SLTU,-2, -4, 0);
        op("XOR7",   F7_ALT,    F3_XOR, 32'hF0F0_0000, 32'h0FF0_000F, 32'hFF00_000F);
        op("MULH",   F7_MULDIV, 3'd1,   -2, -4, 0);
        op("MULHSU", F7_MULDIV, 3'd2,   -2, -4, 32'hFFFF_FFFE);
        op("MULHU",  F7_MULDIV, 3'd3,   -2, -4, 32'hFFFF_FFFA);
        op("DIV",    F7_MULDIV, 3'd4,    8,  2, 4);
        op("DIVn",   F7_MULDIV, 3'd4,   -8,  2, -4);
        op("DIVU",   F7_MULDIV, 3'd5,   16,  3, 5);
        op("DIVUn",  F7_MULDIV, 3'd5,  -16,  3, 32'h5555_5550);
        op("REM",    F7_MULDIV, 3'd6,   10,  3, 1);
        op("REMn",   F7_MULDIV, 3'd6,  -10,  3, -1);
        op("REMU",   F7_MULDIV, 3'd7,  -10,  3, 0);
        op("DIV0",   F7_MULDIV, 3'd4,   77,  0, 32'hFFFF_FFFF);
        op("DIVU0",  F7_MULDIV, 3'd5,   77,  0, 32'hFFFF_FFFF);
        op("REM0",   F7_MULDIV, 3'd6,   -9,  0, -9);
        op("REMU0",  F7_MULDIV, 3'd7,    7,  0, 7);
        op("DIVovf", F7_MULDIV, 3'd4, 32'h8000_0000, -1, 32'h8000_0000);
        op("REMovf", F7_MULDIV, 3'd6, 32'h8000_0000, -1, 0);

        // Register path: rd_q holds the last result, then async reset clears it
        @(posedge clk); #1;
        check("rd_q_pre", rd_q, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", rd_q, 32'd0);
        check("rst_rd", rd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op("OR", F7_BASE, F3_OR, 5, 3, 7);
        check("OR_rd_q_wait", rd_q, 32'd0);
        @(posedge clk); #1;
        check("OR_rd_q", rd_q, 7);
        op("AND", F7_BASE, F3_AND, -5, -3, -7);
        @(posedge clk); #1;
        check("AND_rd_q", rd_q, -7);

        // Random operations against the reference model, rd and rd_q
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       f7 = F7_BASE;
                1:       f7 = F7_ALT;
                2:       f7 = F7_MULDIV;
                default: f7 = 7'($urandom);
            endcase
            f3  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            exp = model(f7, f3, a, b);
            op("rand", f7, f3, a, b, exp);
            @(posedge clk); #1;
            check("rand_rd_q", rd_q, exp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
